// File: rtl/avalon_pio_irq.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear of the
// output register, synchronised edge capture and a maskable level interrupt.
module avalon_pio_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_OUT   = '0,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_MASK   = 3'd2,
    REG_EDGE   = 3'd3,
    REG_OUTSET = 3'd4,
    REG_OUTCLR = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_addr_e;

  localparam int unsigned BLANK_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned CNT_W        = $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  reg_addr_e        addr_sel;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  logic [WIDTH-1:0] out_q, out_next;
  logic [WIDTH-1:0] dir_q, dir_next;
  logic [WIDTH-1:0] mask_q, mask_next;
  logic [WIDTH-1:0] cap_q, cap_next;
  logic [WIDTH-1:0] w1c;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_q;
  logic [CNT_W-1:0] blank_cnt;
  logic             blank_done;

  logic [WIDTH-1:0] rd_val;
  logic [31:0]      rd_word;

  assign addr_sel  = reg_addr_e'(address);
  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Input synchroniser chain and previous-sample register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = in_sync & ~in_prev;
      1:       edge_raw = ~in_sync & in_prev;
      default: edge_raw = in_sync ^ in_prev;
    endcase
  end

  // Edges are ignored until the synchroniser has flushed its reset contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_cnt <= '0;
    end else if (blank_cnt != BLANK_END) begin
      blank_cnt <= blank_cnt + CNT_W'(1);
    end
  end

  assign blank_done = (blank_cnt == BLANK_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= blank_done ? edge_raw : '0;
    end
  end

  always_comb begin
    out_next  = out_q;
    dir_next  = dir_q;
    mask_next = mask_q;
    w1c       = '0;
    if (wr_en) begin
      case (addr_sel)
        REG_DATA:   out_next  = wd;
        REG_DIR:    dir_next  = wd;
        REG_MASK:   mask_next = wd;
        REG_EDGE:   w1c       = wd;
        REG_OUTSET: out_next  = out_q | wd;
        REG_OUTCLR: out_next  = out_q & ~wd;
        default:    ;
      endcase
    end
    // A fresh detection overrides a clear landing on the same edge
    cap_next = (cap_q & ~w1c) | edge_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_OUT[WIDTH-1:0];
      dir_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      out_q  <= out_next;
      dir_q  <= dir_next;
      mask_q <= mask_next;
      cap_q  <= cap_next;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_sel)
      REG_DATA: rd_val = (in_sync & ~dir_q) | (out_q & dir_q);
      REG_DIR:  rd_val = dir_q;
      REG_MASK: rd_val = mask_q;
      REG_EDGE: rd_val = cap_q;
      default:  rd_val = '0;
    endcase
    rd_word              = '0;
    rd_word[WIDTH-1:0]   = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_word;
    end
  end

  assign out_port = out_q;
  assign oe_port  = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Self-checking bench: a rising-edge and an any-edge instance share one bus
// and are compared every cycle against a delay-arithmetic reference model.
module tb_avalon_pio_irq;

  localparam int W  = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = 8'hFF;

  logic [31:0]  rd_r, rd_a;
  logic [W-1:0] out_r, out_a, oe_r, oe_a;
  logic         irq_r, irq_a;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_pio_irq #(.WIDTH(W), .RESET_OUT(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(SS)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_r),
    .in_port(in_port), .out_port(out_r), .oe_port(oe_r), .irq(irq_r));

  avalon_pio_irq #(.WIDTH(W), .RESET_OUT(32'h0), .EDGE_TYPE(2), .SYNC_STAGES(SS)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_port), .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

  // Reference model state
  logic [W-1:0] out_m, dir_m, mask_m, cap_rm, cap_am;
  logic [31:0]  rdm_r, rdm_a;
  logic [W-1:0] samp[$];
  int           n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronised value visible after edge m: the pin sampled SS-1 edges earlier
  function automatic logic [W-1:0] ins(input int m);
    if (m < SS) return '0;
    return samp[m-SS+1];
  endfunction

  function automatic logic [W-1:0] edge_of(input int t, input logic [W-1:0] cur,
                                           input logic [W-1:0] prev);
    if (t == 0) return cur & ~prev;
    if (t == 1) return ~cur & prev;
    return cur ^ prev;
  endfunction

  function automatic logic [31:0] regval(input logic [2:0] a, input logic [W-1:0] cap,
                                         input logic [W-1:0] s);
    case (a)
      3'd0:    return {24'b0, (s & ~dir_m) | (out_m & dir_m)};
      3'd1:    return {24'b0, dir_m};
      3'd2:    return {24'b0, mask_m};
      3'd3:    return {24'b0, cap};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    out_m = '0; dir_m = '0; mask_m = '0; cap_rm = '0; cap_am = '0;
    rdm_r = '0; rdm_a = '0; n = 0;
    samp.delete();
    samp.push_back('0);
  endtask

  task automatic model_step();
    logic [W-1:0] det_r, det_a, w1c, wd;
    n++;
    samp.push_back(in_port);
    wd = writedata[W-1:0];
    if (chipselect && !read_n) begin
      rdm_r = regval(address, cap_rm, ins(n-1));
      rdm_a = regval(address, cap_am, ins(n-1));
    end
    det_r = '0; det_a = '0;
    // Capture lands SS+1 edges after the pin sample, once blanking is over
    if (n - 2 >= SS + 1) begin
      det_r = edge_of(0, ins(n-2), ins(n-3));
      det_a = edge_of(2, ins(n-2), ins(n-3));
    end
    w1c = '0;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: out_m  = wd;
        3'd1: dir_m  = wd;
        3'd2: mask_m = wd;
        3'd3: w1c    = wd;
        3'd4: out_m  = out_m | wd;
        3'd5: out_m  = out_m & ~wd;
        default: ;
      endcase
    end
    cap_rm = (cap_rm & ~w1c) | det_r;
    cap_am = (cap_am & ~w1c) | det_a;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".out_r"}, {24'b0, out_r}, {24'b0, out_m});
    check({ph, ".out_a"}, {24'b0, out_a}, {24'b0, out_m});
    check({ph, ".oe_r"},  {24'b0, oe_r},  {24'b0, dir_m});
    check({ph, ".oe_a"},  {24'b0, oe_a},  {24'b0, dir_m});
    check({ph, ".irq_r"}, {31'b0, irq_r}, {31'b0, |(cap_rm & mask_m)});
    check({ph, ".irq_a"}, {31'b0, irq_a}, {31'b0, |(cap_am & mask_m)});
    check({ph, ".rd_r"},  rd_r, rdm_r);
    check({ph, ".rd_a"},  rd_a, rdm_a);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset(input int cyc);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    repeat (cyc) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int k);
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    repeat (k) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  initial begin
    #2;
    in_port = 8'hFF;
    do_reset(3);
    idle(10);
    bus_read(3'd3);
    check("rst_cap_r", rd_r, 32'h0);
    check("rst_cap_a", rd_a, 32'h0);
    check("rst_out", {24'b0, out_r}, 32'h0);
    check("rst_irq", {31'b0, irq_r}, 32'h0);

    in_port = 8'h3C;
    bus_write(3'd1, 32'h0F);
    bus_write(3'd0, 32'hA5);
    check("data_wr", {24'b0, out_r}, 32'hA5);
    bus_write(3'd4, 32'h50);
    check("outset", {24'b0, out_r}, 32'hF5);
    bus_write(3'd5, 32'h05);
    check("outclear", {24'b0, out_r}, 32'hF0);
    idle(4);
    bus_read(3'd0);
    check("data_rd", rd_r, 32'h30);

    bus_write(3'd2, 32'h01);
    in_port = 8'h3D;
    repeat (3) tick();
    check("rise_early", {31'b0, irq_r}, 32'h0);
    tick();
    check("rise_irq", {31'b0, irq_r}, 32'h1);
    bus_write(3'd3, 32'h01);
    check("w1c_irq", {31'b0, irq_r}, 32'h0);

    in_port = 8'h39;
    idle(6);
    bus_write(3'd2, 32'h04);
    bus_write(3'd3, 32'hFF);
    in_port = 8'h3D;
    repeat (3) tick();
    bus_write(3'd3, 32'h04);
    check("race_irq", {31'b0, irq_r}, 32'h1);
    idle(1);
    check("race_hold", {31'b0, irq_r}, 32'h1);
    bus_read(3'd3);
    check("race_cap", rd_r, 32'h04);

    bus_write(3'd2, 32'h00);
    in_port = 8'hBD;
    idle(5);
    in_port = 8'h3D;
    idle(6);
    check("any_masked", {31'b0, irq_a}, 32'h0);
    bus_read(3'd3);
    check("any_cap7", rd_a & 32'h80, 32'h80);
    bus_write(3'd2, 32'h80);
    check("any_irq", {31'b0, irq_a}, 32'h1);

    bus_read(3'd6);
    check("unmapped", rd_r, 32'h0);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = 3'd1; writedata = 32'h77;
    tick();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    check("rw_old", rd_r, 32'h0F);
    check("rw_new", {24'b0, oe_r}, 32'h77);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        chipselect = ($urandom_range(0, 9) < 7);
        write_n    = $urandom_range(0, 1) == 1;
        read_n     = $urandom_range(0, 1) == 1;
        address    = 3'($urandom_range(0, 7));
        writedata  = $urandom;
        if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom);
        tick();
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
